// File: rtl/mrmac_0_mux_pkg.sv
// mrmac_0_mux_pkg: shared state encoding and mux_sel mode constants for the MRMAC port-mode sequencer.
package mrmac_0_mux_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        FLUSH,
        LRST,
        RELEASE
    } state_t;

    localparam logic [2:0] MODE_100G      = 3'b000;
    localparam logic [2:0] MODE_4X25G     = 3'b001;
    localparam logic [2:0] MODE_2X50G     = 3'b010;
    localparam logic [2:0] MODE_50G_2X25G = 3'b011;
    localparam logic [2:0] MODE_25G_50G   = 3'b100;
    localparam logic [2:0] MODE_2X25G_50G = 3'b110;

    // States in which the drain/flush watchdog is running.
    function automatic logic is_watched(input state_t s);
        return s == DRAIN || s == FLUSH;
    endfunction

endpackage

// File: rtl/mrmac_0_lane_frame_tracker.sv
// mrmac_0_lane_frame_tracker: remembers whether one lane of the stream mux is between the first and last beat of a frame.
module mrmac_0_lane_frame_tracker (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic tvalid,
    input  logic tready,
    input  logic tlast,
    output logic in_frame
);

    always_ff @(posedge clk or posedge reset)
        if (reset)
            in_frame <= 1'b0;
        else if (clr)
            in_frame <= 1'b0;
        else if (tvalid && tready)
            in_frame <= !tlast;

endmodule

// File: rtl/mrmac_0_mux_cfg_sequencer.sv
// mrmac_0_mux_cfg_sequencer: changes the stream-mux port mode safely by holding new frames, draining,
// flushing, pulsing the lane resets and reporting completion or watchdog timeout.
module mrmac_0_mux_cfg_sequencer
    import mrmac_0_mux_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 4096,
    parameter int         RST_CYCLES     = 16,
    parameter logic [2:0] RESET_MODE     = 3'b001
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cfg_req,
    input  logic [2:0] cfg_mode,
    input  logic [3:0] s_tvalid,
    input  logic [3:0] s_tready,
    input  logic [3:0] s_tlast,
    input  logic [3:0] m_tvalid,
    output logic [2:0] mux_sel,
    output logic       hold_req,
    output logic [3:0] lane_reset,
    output logic       cfg_busy,
    output logic       cfg_done,
    output logic       cfg_err
);

    localparam int WW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int RW = $clog2(RST_CYCLES) + 1;
    localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES - 1);

    state_t        state, next_state;
    logic [2:0]    mode_q, mux_sel_d;
    logic [WW-1:0] wd;
    logic [RW-1:0] rcnt;
    logic [3:0]    in_frame, lane_reset_d;
    logic          busy_d, done_d, err_d;
    logic          timeout, same, drained, flushed;

    // Lanes are being reset in LRST, so any half-seen frame is discarded there.
    for (genvar i = 0; i < 4; i++) begin : g_lane
        mrmac_0_lane_frame_tracker u_trk (
            .clk     (clk),
            .reset   (reset),
            .clr     (state == LRST),
            .tvalid  (s_tvalid[i]),
            .tready  (s_tready[i]),
            .tlast   (s_tlast[i]),
            .in_frame(in_frame[i])
        );
    end

    assign timeout = is_watched(state) && wd == WD_LAST;
    assign same    = cfg_req && cfg_mode == mux_sel;
    assign drained = in_frame == 4'b0000;
    assign flushed = m_tvalid == 4'b0000 && s_tready == 4'b1111;

    always_ff @(posedge clk or posedge reset)
        if (reset)
            state <= IDLE;
        else
            state <= next_state;

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = cfg_req && !same ? DRAIN : IDLE;
            DRAIN:   next_state = timeout ? IDLE : drained ? FLUSH : DRAIN;
            FLUSH:   next_state = timeout ? IDLE : flushed ? LRST : FLUSH;
            LRST:    next_state = rcnt == RST_LAST ? RELEASE : LRST;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy_d       = next_state inside {DRAIN, FLUSH, LRST};
        lane_reset_d = {4{next_state == LRST}};
        done_d       = next_state == RELEASE || (state == IDLE && same);
        err_d        = timeout;
        mux_sel_d    = state == FLUSH && next_state == LRST ? mode_q : mux_sel;
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            mux_sel    <= RESET_MODE;
            hold_req   <= 1'b0;
            lane_reset <= 4'b0000;
            cfg_busy   <= 1'b0;
            cfg_done   <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            mux_sel    <= mux_sel_d;
            hold_req   <= busy_d;
            lane_reset <= lane_reset_d;
            cfg_busy   <= busy_d;
            cfg_done   <= done_d;
            cfg_err    <= err_d;
        end

    // Watchdog is held at zero in IDLE, so it always starts from zero on DRAIN entry.
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            mode_q <= RESET_MODE;
            wd     <= '0;
            rcnt   <= '0;
        end else begin
            mode_q <= state == IDLE && cfg_req && !same ? cfg_mode : mode_q;
            wd     <= state == IDLE ? '0 : is_watched(state) ? wd + 1'b1 : wd;
            rcnt   <= state == LRST ? rcnt + 1'b1 : '0;
        end

endmodule

// File: tb/tb_mrmac_0_mux_cfg_sequencer.sv
// tb_mrmac_0_mux_cfg_sequencer: randomized scoreboard bench; the driver predicts each done/err pulse, a monitor checks them.
module tb_mrmac_0_mux_cfg_sequencer;
    import mrmac_0_mux_pkg::*;

    localparam int TO = 64;
    localparam int RC = 16;

    logic       clk = 1'b0, reset = 1'b1, cfg_req = 1'b0;
    logic [2:0] cfg_mode = 3'b000;
    logic [3:0] s_tvalid = 4'h0, s_tready = 4'hF, s_tlast = 4'h0, m_tvalid = 4'h0;
    logic [2:0] mux_sel;
    logic       hold_req, cfg_busy, cfg_done, cfg_err;
    logic [3:0] lane_reset;

    typedef struct {
        bit         err;
        int         cyc;
        logic [2:0] sel;
    } exp_t;

    exp_t       sb[$];
    exp_t       got_e;
    int         tests = 0, fails = 0, cyc = 0, run = 0;
    bit         abort = 1'b0;
    logic [2:0] cur = 3'b001;
    logic [2:0] modes[6] = '{MODE_100G, MODE_4X25G, MODE_2X50G, MODE_50G_2X25G, MODE_25G_50G, MODE_2X25G_50G};

    mrmac_0_mux_cfg_sequencer #(
        .TIMEOUT_CYCLES(TO),
        .RST_CYCLES    (RC),
        .RESET_MODE    (3'b001)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_req   (cfg_req),
        .cfg_mode  (cfg_mode),
        .s_tvalid  (s_tvalid),
        .s_tready  (s_tready),
        .s_tlast   (s_tlast),
        .m_tvalid  (m_tvalid),
        .mux_sel   (mux_sel),
        .hold_req  (hold_req),
        .lane_reset(lane_reset),
        .cfg_busy  (cfg_busy),
        .cfg_done  (cfg_done),
        .cfg_err   (cfg_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int mx(input int a, input int b);
        return a > b ? a : b;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Monitor: every pulse must match the oldest prediction; lane_reset must be a full-width level of RC cycles.
    always @(negedge clk) begin
        if (cfg_done || cfg_err) begin
            if (sb.size() == 0)
                chk("unexpected_pulse", {30'd0, cfg_err, cfg_done}, 0);
            else begin
                got_e = sb.pop_front();
                chk("pulse_kind", {30'd0, cfg_err, cfg_done}, got_e.err ? 2 : 1);
                chk("pulse_cycle", cyc, got_e.cyc);
                chk("pulse_mux_sel", {29'd0, mux_sel}, {29'd0, got_e.sel});
                chk("pulse_hold_req", {31'd0, hold_req}, 0);
            end
        end
        if (reset || abort)
            run = 0;
        else if (lane_reset != 4'h0) begin
            chk("lane_reset_level", {28'd0, lane_reset}, 32'hF);
            run++;
        end else if (run > 0) begin
            chk("lane_reset_len", run, RC);
            run = 0;
        end
    end

    // One reconfiguration: open frames on 'open' lanes, request, close them k cycles later,
    // keep m_tvalid busy for mc cycles after the request, optionally fire a second request while busy.
    task automatic txn(input logic [2:0] mode, input logic [3:0] open, input int k, input int mc, input bit extra);
        int   r, t, m, d, x, last, xr;
        bit   same, saw;
        exp_t e;
        saw = 1'b0;
        @(negedge clk);
        s_tvalid = 4'hF;
        s_tlast  = ~open;
        m_tvalid = 4'h0;
        @(negedge clk);
        s_tvalid = 4'h0;
        s_tlast  = 4'h0;
        cfg_req  = 1'b1;
        cfg_mode = mode;
        r = cyc;
        t = r + k;
        m = r + mc;
        same = (mode == cur);
        d = open != 4'h0 ? t + 1 : r + 1;
        x = mx(d + 1, m);
        if (same) begin
            e = '{err: 1'b0, cyc: r + 1, sel: cur};
            xr = -1;
        end else if (x >= r + TO) begin
            e = '{err: 1'b1, cyc: r + TO + 1, sel: cur};
            xr = r + 10;
        end else begin
            e = '{err: 1'b0, cyc: x + RC + 1, sel: mode};
            xr = x + 5;
            cur = mode;
        end
        if (!extra) xr = -1;
        sb.push_back(e);
        last = mx(mx(e.cyc, t + 1), m) + 3;
        while (cyc < last) begin
            @(negedge clk);
            cfg_req  = 1'b0;
            s_tvalid = cyc == t ? open : (cyc < t ? open & 4'($urandom) : 4'h0);
            s_tlast  = cyc == t ? open : 4'h0;
            m_tvalid = cyc < m ? (4'b0010 | 4'($urandom)) : 4'h0;
            if (cyc == xr) begin
                cfg_req  = 1'b1;
                cfg_mode = mode ^ 3'b101;
            end
            if (same && (hold_req || lane_reset != 4'h0)) saw = 1'b1;
        end
        if (same) chk("same_mode_quiet", {31'd0, saw}, 0);
        chk("idle_busy", {31'd0, cfg_busy}, 0);
        chk("final_mux_sel", {29'd0, mux_sel}, {29'd0, cur});
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_mux_sel"}, {29'd0, mux_sel}, 1);
        chk({tag, "_hold_req"}, {31'd0, hold_req}, 0);
        chk({tag, "_lane_reset"}, {28'd0, lane_reset}, 0);
        chk({tag, "_busy"}, {31'd0, cfg_busy}, 0);
        chk({tag, "_done_err"}, {30'd0, cfg_done, cfg_err}, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int r;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        reset = 1'b0;
        repeat (2) @(negedge clk);
        txn(MODE_100G, 4'h0, 1, 100, 1'b1);
        txn(MODE_4X25G, 4'b0011, 5, 3, 1'b0);
        txn(MODE_100G, 4'h0, 1, 0, 1'b1);
        txn(MODE_2X50G, 4'b0100, 40, 0, 1'b1);
        txn(MODE_50G_2X25G, 4'h0, 1, 63, 1'b1);
        txn(MODE_25G_50G, 4'h0, 1, 64, 1'b1);
        txn(MODE_2X25G_50G, 4'b1000, 63, 0, 1'b1);
        for (int i = 0; i < 24; i++)
            txn(modes[$urandom_range(0, 5)], 4'($urandom), $urandom_range(1, 40),
                ($urandom_range(0, 4) == 0) ? $urandom_range(60, 90) : $urandom_range(0, 40),
                1'(($urandom & 1)));
        @(negedge clk);
        cfg_req  = 1'b1;
        cfg_mode = cur ^ 3'b011;
        m_tvalid = 4'h0;
        r = cyc;
        @(negedge clk);
        cfg_req = 1'b0;
        repeat (7) @(negedge clk);
        chk("pre_reset_lrst", {28'd0, lane_reset}, 32'hF);
        chk("pre_reset_cycle", cyc, r + 8);
        abort = 1'b1;
        reset = 1'b1;
        #1;
        chk_reset_vals("async_reset");
        @(negedge clk);
        reset = 1'b0;
        repeat (25) @(negedge clk);
        abort = 1'b0;
        cur = 3'b001;
        chk("after_abort_mux_sel", {29'd0, mux_sel}, 1);
        txn(MODE_2X25G_50G, 4'b0101, 7, 12, 1'b1);
        repeat (5) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
